// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one outstanding access, aligned bus word requests, extended load data
module lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        mem_wen_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic        bus_wen_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wmask_o,
  input  logic        bus_rsp_valid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_rsp_err_i
);

  typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT, RESP} state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;
  logic        resp_valid_q, err_q, bus_req_valid_q, bus_wen_q;
  logic [31:0] rdata_q, bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_wmask_q;

  logic        bad_d;
  logic [31:0] bus_wdata_d, load_d, shifted_d;
  logic [3:0]  bus_wmask_d;
  logic [15:0] half_d;

  always_comb begin
    // Reserved encodings, unsigned stores, or a size not naturally aligned.
    bad_d = (mem_op_i == 3'b011) || (mem_op_i[2:1] == 2'b11) || (mem_wen_i && mem_op_i[2]) ||
            (mem_op_i[1:0] == 2'b01 && addr_i[0]) ||
            (mem_op_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    bus_wdata_d = 32'd0;
    bus_wmask_d = 4'b0000;
    if (mem_wen_i) begin
      case (mem_op_i[1:0])
        2'b00: begin
          bus_wdata_d = {4{wdata_i[7:0]}};
          bus_wmask_d = 4'b0001 << addr_i[1:0];
        end
        2'b01: begin
          bus_wdata_d = {2{wdata_i[15:0]}};
          bus_wmask_d = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          bus_wdata_d = wdata_i;
          bus_wmask_d = 4'b1111;
        end
      endcase
    end
    shifted_d = bus_rdata_i >> {lo_q, 3'b000};
    half_d    = lo_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (op_q)
      3'b000:  load_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b100:  load_d = {24'd0, shifted_d[7:0]};
      3'b001:  load_d = {{16{half_d[15]}}, half_d};
      3'b101:  load_d = {16'd0, half_d};
      default: load_d = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      op_q            <= 3'd0;
      lo_q            <= 2'd0;
      resp_valid_q    <= 1'b0;
      err_q           <= 1'b0;
      rdata_q         <= 32'd0;
      bus_req_valid_q <= 1'b0;
      bus_wen_q       <= 1'b0;
      bus_addr_q      <= 32'd0;
      bus_wdata_q     <= 32'd0;
      bus_wmask_q     <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          op_q <= mem_op_i;
          lo_q <= addr_i[1:0];
          if (bad_d) begin
            err_q        <= 1'b1;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            bus_addr_q      <= {addr_i[31:2], 2'b00};
            bus_wen_q       <= mem_wen_i;
            bus_wdata_q     <= bus_wdata_d;
            bus_wmask_q     <= bus_wmask_d;
            bus_req_valid_q <= 1'b1;
            state_q         <= BUS_REQ;
          end
        end
        BUS_REQ: if (bus_req_ready_i) begin
          bus_req_valid_q <= 1'b0;
          state_q         <= BUS_WAIT;
        end
        BUS_WAIT: if (bus_rsp_valid_i) begin
          err_q        <= bus_rsp_err_i;
          rdata_q      <= (bus_rsp_err_i || bus_wen_q) ? 32'd0 : load_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (resp_ready_i) begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign resp_valid_o    = resp_valid_q;
  assign rdata_o         = rdata_q;
  assign err_o           = err_q;
  assign bus_req_valid_o = bus_req_valid_q;
  assign bus_wen_o       = bus_wen_q;
  assign bus_addr_o      = bus_addr_q;
  assign bus_wdata_o     = bus_wdata_q;
  assign bus_wmask_o     = bus_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: directed cases plus randomized accesses against a reference model
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        mem_wen = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] rdata;
  logic        err;
  logic        bus_req_valid, bus_req_ready = 1'b0, bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0, passes = 0, fails = 0;

  lsu dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .mem_wen_i(mem_wen), .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .rdata_o(rdata), .err_o(err),
    .bus_req_valid_o(bus_req_valid), .bus_req_ready_i(bus_req_ready),
    .bus_wen_o(bus_wen), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_wmask_o(bus_wmask),
    .bus_rsp_valid_i(bus_rsp_valid), .bus_rdata_i(bus_rdata), .bus_rsp_err_i(bus_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected behaviour from access size and byte offset arithmetic.
  task automatic model(input bit wen, input logic [2:0] op, input logic [31:0] a, wd, brd,
                       input bit berr, output bit legal, output logic [31:0] e_addr, e_wd,
                       output logic [3:0] e_mask, output logic [31:0] e_rd, output bit e_err);
    int size, off;
    logic [31:0] m, v;
    size  = 1 << op[1:0];
    off   = a % 4;
    legal = (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(wen && op >= 4) && (a % size == 0);
    e_addr = a - off;
    m = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    e_wd = 32'd0;
    e_mask = 4'd0;
    if (wen && legal) begin
      e_wd   = (wd & m) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
      e_mask = 4'(((1 << size) - 1) << off);
    end
    if (!legal || berr) begin
      e_rd = 32'd0; e_err = 1'b1;
    end else if (wen) begin
      e_rd = 32'd0; e_err = 1'b0;
    end else begin
      v = (brd >> (8 * off)) & m;
      if (op < 4 && size < 4 && v[8 * size - 1]) v = v | ~m;
      e_rd = v; e_err = 1'b0;
    end
  endtask

  task automatic run_txn(input string tag, input bit wen, input logic [2:0] op,
                         input logic [31:0] a, wd, brd, input bit berr,
                         input int rq_dly, input int ack_dly);
    bit legal, e_err, done, hs_prev;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_mask;
    int t, bus_seen, resp_seen, bus_hs, bus_first, resp_first;
    model(wen, op, a, wd, brd, berr, legal, e_addr, e_wd, e_mask, e_rd, e_err);
    @(negedge clk);
    check({tag, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; mem_wen = wen; mem_op = op; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; wdata = $urandom; addr = $urandom;
    done = 0; hs_prev = 0; bus_seen = 0; resp_seen = 0; bus_hs = 0;
    bus_first = -1; resp_first = -1; t = 1;
    while (!done && t < 60) begin
      bus_rsp_valid = hs_prev; bus_rdata = brd; bus_rsp_err = berr;
      if (bus_req_valid) begin
        if (bus_first < 0) bus_first = t;
        check({tag, ":bus_addr"}, bus_addr, e_addr);
        check({tag, ":bus_wen"}, 32'(bus_wen), 32'(wen));
        check({tag, ":bus_wdata"}, bus_wdata, e_wd);
        check({tag, ":bus_wmask"}, 32'(bus_wmask), 32'(e_mask));
        bus_req_ready = (bus_seen >= rq_dly);
        bus_seen++;
      end else bus_req_ready = 1'b0;
      hs_prev = bus_req_valid && bus_req_ready;
      if (hs_prev) bus_hs++;
      if (resp_valid) begin
        if (resp_first < 0) resp_first = t;
        check({tag, ":rdata"}, rdata, e_rd);
        check({tag, ":err"}, 32'(err), 32'(e_err));
        resp_ready = (resp_seen >= ack_dly);
        done = resp_ready;
        resp_seen++;
      end else resp_ready = 1'b0;
      check({tag, ":req_ready_busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      t++;
    end
    resp_ready = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    check({tag, ":completed"}, 32'(done), 32'd1);
    check({tag, ":bus_handshakes"}, bus_hs, legal ? 32'd1 : 32'd0);
    if (rq_dly == 0) begin
      check({tag, ":resp_latency"}, resp_first, legal ? 32'd3 : 32'd1);
      if (legal) check({tag, ":bus_latency"}, bus_first, 32'd1);
    end
    check({tag, ":req_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, ":resp_valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int ops[8] = '{0, 1, 2, 4, 5, 0, 2, 3};
    int bad_ops[3] = '{3, 6, 7};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:resp_valid", 32'(resp_valid), 32'd0);
    check("rst:bus_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst:bus_wen", 32'(bus_wen), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:rdata", rdata, 32'd0);
    check("rst:bus_addr", bus_addr, 32'd0);
    check("rst:bus_wdata", bus_wdata, 32'd0);
    check("rst:bus_wmask", 32'(bus_wmask), 32'd0);

    run_txn("lb", 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    check("lb:exact_rdata", rdata, 32'hFFFF_FF80);
    run_txn("lhu", 0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 0, 0);
    check("lhu:exact_rdata", rdata, 32'h0000_BEEF);
    run_txn("lh", 0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 0, 0);
    check("lh:exact_rdata", rdata, 32'hFFFF_BEEF);
    run_txn("sh", 1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 0, 0);
    check("sh:exact_wdata", bus_wdata, 32'hABCD_ABCD);
    run_txn("lw_mis", 0, 3'b010, 32'h8000_0001, 32'h0, 32'h1111_1111, 0, 0, 0);
    run_txn("sb_u", 1, 3'b100, 32'h8000_0000, 32'hFF, 32'h0, 0, 0, 0);
    run_txn("stall", 0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 0, 3, 2);
    run_txn("buserr", 0, 3'b000, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 1, 1, 1);

    // A stray bus response in IDLE must not disturb anything.
    @(negedge clk);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check("stray:resp_valid", 32'(resp_valid), 32'd0);
    check("stray:req_ready", 32'(req_ready), 32'd1);

    // Reset while BUS_WAIT, then the abandoned response arrives.
    req_valid = 1'b1; mem_wen = 1'b0; mem_op = 3'b010; addr = 32'h8000_0020;
    bus_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstwait:bus_req_valid", 32'(bus_req_valid), 32'd1);
    @(negedge clk);
    bus_req_ready = 1'b0;
    check("rstwait:in_wait", 32'(bus_req_valid | resp_valid | req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check("rstwait:resp_valid", 32'(resp_valid), 32'd0);
    check("rstwait:req_ready", 32'(req_ready), 32'd1);
    run_txn("sw_after_rst", 1, 3'b010, 32'h8000_0010, 32'h0BAD_CAFE, 32'h0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      bit wen;
      op  = 3'(ops[$urandom_range(0, 7)]);
      if ($urandom_range(0, 9) == 0) op = 3'(bad_ops[$urandom_range(0, 2)]);
      wen = (op inside {3'd0, 3'd1, 3'd2}) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      run_txn("rand", wen, op, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
